// File: rtl/gemm_pkg.sv
// Shared types for the 2x2 GEMM K-slice sequencer.
// Operand/accumulator types, FSM state encoding, default watchdog limit.
package gemm_pkg;

  typedef logic signed [7:0]  op_t;
  typedef logic signed [31:0] acc_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    DONE
  } gemm_seq_state_e;

  localparam int unsigned TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/gemm_psum_bank.sv
// Four 32-bit partial-sum registers for the 2x2 output tile.
// Ports: clk, rst (sync, active-high), clr (zero all), ld (load y*), y00..y11 in, p00..p11 out.
module gemm_psum_bank
  import gemm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ld,
  input  acc_t y00,
  input  acc_t y01,
  input  acc_t y10,
  input  acc_t y11,
  output acc_t p00,
  output acc_t p01,
  output acc_t p10,
  output acc_t p11
);

  acc_t p_q [4];
  acc_t p_d [4];

  // clr wins over ld; both are single-cycle strobes from the sequencer.
  always_comb begin
    p_d = p_q;
    if (clr) begin
      p_d = '{default: '0};
    end else if (ld) begin
      p_d[0] = y00;
      p_d[1] = y01;
      p_d[2] = y10;
      p_d[3] = y11;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        p_q[i] <= '0;
      end
    end else begin
      p_q <= p_d;
    end
  end

  assign p00 = p_q[0];
  assign p01 = p_q[1];
  assign p10 = p_q[2];
  assign p11 = p_q[3];

endmodule

// File: rtl/gemm_kslice_seq.sv
// Sequencer feeding a 2x2 MAC array one int8 K-slice at a time, holding
// 32-bit partial sums between slices and presenting the final C tile.
// Ports: clk, rst (sync, active-high); start/k_len/busy control;
// s_valid/s_ready/s_a*/s_b* slice stream; mac_in_valid/mac_a*/mac_b*/mac_acc*
// issue side; mac_out_valid/mac_y* array results; res_valid/res_ready/c*
// result port; err watchdog pulse.
// Optional watchdog in WAIT: define GEMM_SEQ_WDOG_EN (otherwise err = 0).
module gemm_kslice_seq
  import gemm_pkg::*;
#(
  parameter int unsigned K_W         = 8,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [K_W-1:0] k_len,
  output logic           busy,
  input  logic           s_valid,
  output logic           s_ready,
  input  op_t            s_a0,
  input  op_t            s_a1,
  input  op_t            s_b0,
  input  op_t            s_b1,
  output logic           mac_in_valid,
  output op_t            mac_a0,
  output op_t            mac_a1,
  output op_t            mac_b0,
  output op_t            mac_b1,
  output acc_t           mac_acc00,
  output acc_t           mac_acc01,
  output acc_t           mac_acc10,
  output acc_t           mac_acc11,
  input  logic           mac_out_valid,
  input  acc_t           mac_y00,
  input  acc_t           mac_y01,
  input  acc_t           mac_y10,
  input  acc_t           mac_y11,
  output logic           res_valid,
  input  logic           res_ready,
  output acc_t           c00,
  output acc_t           c01,
  output acc_t           c10,
  output acc_t           c11,
  output logic           err
);

  gemm_seq_state_e state_q, state_d;
  logic [K_W-1:0]  cnt_q, cnt_d;
  logic [K_W-1:0]  cnt_dec;
  op_t             a0_q, a0_d;
  op_t             a1_q, a1_d;
  op_t             b0_q, b0_d;
  op_t             b1_q, b1_d;
  logic            busy_q, busy_d;
  logic            miv_q, miv_d;
  logic            rv_q, rv_d;
  logic            ps_clr;
  logic            ps_ld;
  logic            tmo;

  assign cnt_dec = cnt_q - K_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    ps_clr  = 1'b0;
    ps_ld   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ps_clr  = 1'b1;
          cnt_d   = k_len;
          state_d = (k_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        // s_ready is high throughout FETCH, so s_valid alone is the handshake.
        if (s_valid) begin
          a0_d    = s_a0;
          a1_d    = s_a1;
          b0_d    = s_b0;
          b1_d    = s_b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mac_out_valid) begin
          ps_ld   = 1'b1;
          cnt_d   = cnt_dec;
          state_d = (cnt_dec == '0) ? DONE : FETCH;
        end else if (tmo) begin
          ps_clr  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Moore outputs registered from the next state.
    busy_d = (state_d != IDLE);
    miv_d  = (state_d == ISSUE);
    rv_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      busy_q  <= 1'b0;
      miv_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      busy_q  <= busy_d;
      miv_q   <= miv_d;
      rv_q    <= rv_d;
    end
  end

`ifdef GEMM_SEQ_WDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  // Counts WAIT cycles without a result; cleared everywhere else.
  always_comb begin
    wd_d = '0;
    if (state_q == WAIT && !mac_out_valid) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  assign tmo = (state_q == WAIT) && !mac_out_valid &&
               (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign err_d = tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_tmo;

  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo        = 1'b0;
  assign err        = 1'b0;
`endif

  gemm_psum_bank u_psum (
    .clk (clk),
    .rst (rst),
    .clr (ps_clr),
    .ld  (ps_ld),
    .y00 (mac_y00),
    .y01 (mac_y01),
    .y10 (mac_y10),
    .y11 (mac_y11),
    .p00 (mac_acc00),
    .p01 (mac_acc01),
    .p10 (mac_acc10),
    .p11 (mac_acc11)
  );

  assign c00 = mac_acc00;
  assign c01 = mac_acc01;
  assign c10 = mac_acc10;
  assign c11 = mac_acc11;

  assign busy         = busy_q;
  assign s_ready      = (state_q == FETCH);
  assign mac_in_valid = miv_q;
  assign mac_a0       = a0_q;
  assign mac_a1       = a1_q;
  assign mac_b0       = b0_q;
  assign mac_b1       = b1_q;
  assign res_valid    = rv_q;

endmodule
